// File: rtl/exec_issuer.sv
// Execute-unit issuer: holds one request, pulses alu_enabled, waits for alu_completed (or watchdog), returns result.
// Latency: req handshake N -> alu_enabled N+1 -> rsp_valid N+3 with a 1-cycle ALU. Backpressure: req_ready low while busy; rsp held until rsp_ready.
// Optional EXEC_ISSUER_PIPE_EN: accept the next request in DONE on the same cycle as the response handshake.
module exec_issuer #(
    parameter int PAYLOAD_W = 128,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PAYLOAD_W-1:0] req_instr,
    input  logic [31:0]          req_rs1,
    input  logic [31:0]          req_rs2,
    output logic                 alu_enabled,
    output logic [PAYLOAD_W-1:0] alu_instr,
    output logic [31:0]          alu_rs1,
    output logic [31:0]          alu_rs2,
    input  logic                 alu_completed,
    input  logic [31:0]          alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;

    // req_ready is gated by rstn so it stays low while reset is asserted.
    always_comb begin
        req_ready = 1'b0;
        if (rstn && !flush) begin
            if (state == S_IDLE) begin
                req_ready = 1'b1;
            end
`ifdef EXEC_ISSUER_PIPE_EN
            else if (state == S_DONE) begin
                req_ready = rsp_ready;
            end
`endif
        end
    end

    assign accept      = req_valid && req_ready;
    assign alu_enabled = (state == S_ISSUE);
    assign rsp_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            alu_instr <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_instr <= req_instr;
                        alu_rs1   <= req_rs1;
                        alu_rs2   <= req_rs2;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the last watchdog cycle still counts as a real result.
                    if (alu_completed) begin
                        rsp_data <= alu_result;
                        rsp_err  <= 1'b0;
                        state    <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        // accept can only be true here when pipelining is enabled.
                        if (accept) begin
                            alu_instr <= req_instr;
                            alu_rs1   <= req_rs1;
                            alu_rs2   <= req_rs2;
                            state     <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_issuer.sv
// Directed bench for exec_issuer with a delay-programmable ALU model.
`timescale 1ns/1ps
module tb_exec_issuer;

    localparam int PW = 128;
    localparam logic [PW-1:0] ADD_INSTR = 128'h0000_0000_0000_0000_0000_0000_0040_0033;
`ifdef EXEC_ISSUER_PIPE_EN
    localparam int EXP_SPACING = 3;
`else
    localparam int EXP_SPACING = 4;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [PW-1:0] req_instr = '0;
    logic [31:0]   req_rs1 = '0;
    logic [31:0]   req_rs2 = '0;
    logic          alu_enabled;
    logic [PW-1:0] alu_instr;
    logic [31:0]   alu_rs1;
    logic [31:0]   alu_rs2;
    logic          alu_completed = 1'b0;
    logic [31:0]   alu_result = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // ALU model: completes alu_delay cycles after the enabled pulse; 0 means never.
    int          alu_delay = 1;
    logic [31:0] alu_res_val = '0;
    int          cd = 0;
    bit          pend = 0;

    exec_issuer #(.PAYLOAD_W(PW), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .alu_enabled(alu_enabled), .alu_instr(alu_instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_completed(alu_completed), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        alu_completed = 1'b0;
        if (!rstn) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (cd == 1) begin
                    alu_completed = 1'b1;
                    alu_result    = alu_res_val;
                    pend          = 0;
                end else begin
                    cd = cd - 1;
                end
            end
            if (alu_enabled && alu_delay > 0) begin
                pend = 1;
                cd   = alu_delay;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_instr = ADD_INSTR;
        req_rs1   = a;
        req_rs2   = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #3;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        n_cmp++; if ({alu_enabled, rsp_valid, busy, rsp_err} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl got %b want 0000", {alu_enabled, rsp_valid, busy, rsp_err}); end
        n_cmp++; if (rsp_data !== 32'd0 || alu_rs1 !== 32'd0) begin n_err++; $display("FAIL reset_data got %h/%h want 0", rsp_data, alu_rs1); end
        tick();
        rstn = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_req_ready got %b want 1", req_ready); end
        tick();
    endtask

    task automatic test_basic_and_hold;
        alu_delay = 1; alu_res_val = 32'd12; rsp_ready = 1'b0;
        send_req(32'd5, 32'd7);
        n_cmp++; if (alu_enabled !== 1'b1) begin n_err++; $display("FAIL issue_pulse_n1 got %b want 1", alu_enabled); end
        n_cmp++; if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7 || alu_instr !== ADD_INSTR) begin n_err++; $display("FAIL issue_operands got %0d/%0d want 5/7", alu_rs1, alu_rs2); end
        tick();
        n_cmp++; if (alu_enabled !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL n2_state got en=%b vld=%b want 0/0", alu_enabled, rsp_valid); end
        n_cmp++; if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin n_err++; $display("FAIL wait_operands got %0d/%0d want 5/7", alu_rs1, alu_rs2); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_err !== 1'b0) begin n_err++; $display("FAIL rsp_n3 got vld=%b data=%0d err=%b want 1/12/0", rsp_valid, rsp_data, rsp_err); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || req_ready !== 1'b0) begin n_err++; $display("FAIL rsp_hold[%0d] got vld=%b data=%0d rdy=%b want 1/12/0", i, rsp_valid, rsp_data, req_ready); end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL back_to_idle got busy=%b vld=%b rdy=%b want 0/0/1", busy, rsp_valid, req_ready); end
    endtask

    task automatic test_timeout;
        alu_delay = 0;
        send_req(32'd1, 32'd2);
        tick();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL timeout_early[%0d] got vld=%b want 0", i, rsp_valid); end
            tick();
        end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_err !== 1'b1) begin n_err++; $display("FAIL timeout_rsp got vld=%b data=%h err=%b want 1/0/1", rsp_valid, rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_last_cycle_complete;
        alu_delay = 16; alu_res_val = 32'hDEADBEEF;
        send_req(32'd3, 32'd4);
        for (int i = 0; i < 16; i++) tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL w16_not_done got vld=%b want 0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0) begin n_err++; $display("FAIL late_complete got vld=%b data=%h err=%b want 1/deadbeef/0", rsp_valid, rsp_data, rsp_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_flush;
        alu_delay = 2; alu_res_val = 32'h55;
        send_req(32'd9, 32'd9);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle got busy=%b vld=%b rdy=%b want 0/0/1", busy, rsp_valid, req_ready); end
        tick();
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL late_completion got busy=%b vld=%b want 0/0", busy, rsp_valid); end
        flush = 1'b1; req_valid = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_gates_ready got %b want 0", req_ready); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_no_accept got busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_back_to_back;
        int issue_cyc[3];
        int n_iss = 0;
        alu_delay = 1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_instr = ADD_INSTR; req_rs1 = 32'd1; req_rs2 = 32'd1;
        for (int i = 0; i < 20 && n_iss < 3; i++) begin
            tick();
            if (alu_enabled) begin issue_cyc[n_iss] = cyc; n_iss++; end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (n_iss < 3) begin
            n_err++; $display("FAIL b2b_issue_count got %0d want 3", n_iss);
        end else begin
            n_cmp++; if (issue_cyc[1] - issue_cyc[0] != EXP_SPACING) begin n_err++; $display("FAIL b2b_spacing0 got %0d want %0d", issue_cyc[1] - issue_cyc[0], EXP_SPACING); end
            if (issue_cyc[2] - issue_cyc[1] != EXP_SPACING) begin n_err++; $display("FAIL b2b_spacing1 got %0d want %0d", issue_cyc[2] - issue_cyc[1], EXP_SPACING); end
        end
        for (int i = 0; i < 6; i++) tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        alu_delay = 0;
        send_req(32'hA5, 32'h5A);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++; if ({req_ready, alu_enabled, rsp_valid, busy, rsp_err} !== 5'b0) begin n_err++; $display("FAIL async_rst_ctrl got %b want 00000", {req_ready, alu_enabled, rsp_valid, busy, rsp_err}); end
        n_cmp++; if (alu_rs1 !== 32'd0 || alu_rs2 !== 32'd0 || alu_instr !== '0 || rsp_data !== 32'd0) begin n_err++; $display("FAIL async_rst_data got %h/%h want 0/0", alu_rs1, alu_rs2); end
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_and_hold();
        test_timeout();
        test_last_cycle_complete();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
